// File: rtl/harvos_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// harvos_memresp_pkg
// Shared definitions for the HarvOS memory responder slice:
//   memresp_state_t   - responder FSM state encoding (IDLE, WAIT, RESP, TURN)
//   MEMRESP_LFSR_SEED - value loaded into the stall LFSR on reset
//   MEMRESP_LFSR_TAPS - feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
//   memresp_lfsr_next - one Fibonacci shift step of the stall LFSR
// ---------------------------------------------------------------------------
package harvos_memresp_pkg;

    typedef enum logic [1:0] {
        MEMRESP_IDLE = 2'd0,
        MEMRESP_WAIT = 2'd1,
        MEMRESP_RESP = 2'd2,
        MEMRESP_TURN = 2'd3
    } memresp_state_t;

    localparam logic [15:0] MEMRESP_LFSR_SEED = 16'hACE1;
    localparam logic [15:0] MEMRESP_LFSR_TAPS = 16'hB400;

    // Shift towards the MSB and feed the XOR of the tapped bits into bit 0.
    function automatic logic [15:0] memresp_lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & MEMRESP_LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/harvos_mem_responder_if.sv
// ---------------------------------------------------------------------------
// harvos_mem_responder_if
// HarvOS req/rvalid memory bus bundle.
//   master modport: drives req, we, be, addr, wdata; observes rdata, rvalid,
//                   fault, busy
//   slave modport : the responder side, directions reversed
// ---------------------------------------------------------------------------
interface harvos_mem_responder_if;

    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        fault;
    logic        busy;

    modport master (
        output req, we, be, addr, wdata,
        input  rdata, rvalid, fault, busy
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output rdata, rvalid, fault, busy
    );

endinterface

// File: rtl/harvos_mem_responder_lfsr.sv
// ---------------------------------------------------------------------------
// harvos_memresp_lfsr
// 16-bit Fibonacci LFSR used to inject random wait states.
//   clk    - clock
//   rst    - synchronous active-high reset, loads MEMRESP_LFSR_SEED
//   en_i   - advance one step per cycle while high
//   lfsr_o - current LFSR state
// ---------------------------------------------------------------------------
module harvos_memresp_lfsr (
    input  logic        clk,
    input  logic        rst,
    input  logic        en_i,
    output logic [15:0] lfsr_o
);
    import harvos_memresp_pkg::*;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) begin
            lfsr_d = memresp_lfsr_next(lfsr_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= MEMRESP_LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/harvos_mem_responder.sv
// ---------------------------------------------------------------------------
// harvos_mem_responder
// Target end of the HarvOS req/rvalid protocol: a word-organised RAM window
// at BASE_ADDR that answers one request at a time after a fixed latency.
//   clk - clock
//   rst - synchronous active-high reset (RAM contents are kept)
//   bus - slave side of harvos_mem_responder_if (req/we/be/addr/wdata in,
//         rdata/rvalid/fault/busy out)
// Parameters: WORDS (RAM depth, power of two), BASE_ADDR (byte base),
//             LATENCY (accept-to-rvalid cycles, >= 1).
// Optional build macro HARVOS_MEMRESP_RANDSTALL_EN: adds 0..3 LFSR-chosen
// wait cycles to each request's latency.
// ---------------------------------------------------------------------------
module harvos_mem_responder #(
    parameter int unsigned WORDS     = 4096,
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int unsigned LATENCY   = 2
) (
    input logic                   clk,
    input logic                   rst,
    harvos_mem_responder_if.slave bus
);
    import harvos_memresp_pkg::*;

    localparam logic [1:0]  ST_IDLE      = MEMRESP_IDLE;
    localparam logic [1:0]  ST_WAIT      = MEMRESP_WAIT;
    localparam logic [1:0]  ST_RESP      = MEMRESP_RESP;
    localparam logic [1:0]  ST_TURN      = MEMRESP_TURN;
    localparam int          IDX_W        = $clog2(WORDS);
    localparam int          CNT_W        = $clog2(LATENCY + 4) + 1;
    localparam logic [32:0] WINDOW_BYTES = 33'(WORDS) * 33'd4;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q;
    logic [3:0]       be_q;
    logic [31:0]      addr_q, wdata_q;
    logic [31:0]      rdata_q;
    logic             fault_q;
    logic [31:0]      mem [WORDS];

    logic [1:0]       extraStall;
    logic [CNT_W-1:0] totalLat;
    logic             accWe;
    logic [3:0]       accBe;
    logic [31:0]      accAddr, accWdata, accOff;
    logic [IDX_W-1:0] accIdx;
    logic             accFault;
    logic             enterResp;

`ifdef HARVOS_MEMRESP_RANDSTALL_EN
    logic [15:0] lfsrState;

    harvos_memresp_lfsr u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .en_i   (1'b1),
        .lfsr_o (lfsrState)
    );

    assign extraStall = lfsrState[1:0];
`else
    assign extraStall = 2'd0;
`endif

    assign totalLat = CNT_W'(LATENCY) + CNT_W'(extraStall);

    // With a one-cycle latency RESP is entered straight from IDLE, before the
    // request has been latched, so the access uses the live bus fields then.
    assign accWe    = (state_q == ST_IDLE) ? bus.we    : we_q;
    assign accBe    = (state_q == ST_IDLE) ? bus.be    : be_q;
    assign accAddr  = (state_q == ST_IDLE) ? bus.addr  : addr_q;
    assign accWdata = (state_q == ST_IDLE) ? bus.wdata : wdata_q;

    // Unsigned offset wraps for addresses below the base, hence the explicit
    // lower-bound compare alongside the window-size check.
    assign accOff   = accAddr - BASE_ADDR;
    assign accIdx   = accOff[IDX_W+1:2];
    assign accFault = (accAddr < BASE_ADDR) || ({1'b0, accOff} >= WINDOW_BYTES) ||
                      (accAddr[1:0] != 2'b00);

    assign enterResp = (state_d == ST_RESP);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    if (totalLat <= CNT_W'(1)) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = totalLat - CNT_W'(2);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_TURN;
            ST_TURN: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == ST_IDLE && bus.req) begin
                we_q    <= bus.we;
                be_q    <= bus.be;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end
            // Response registers only carry data during the RESP cycle.
            if (enterResp) begin
                fault_q <= accFault;
                rdata_q <= (!accFault && !accWe) ? mem[accIdx] : 32'h0;
            end else begin
                fault_q <= 1'b0;
                rdata_q <= 32'h0;
            end
        end
    end

    // RAM is never reset; a reset on the RESP-entry edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && enterResp && accWe && !accFault) begin
            for (int i = 0; i < 4; i++) begin
                if (accBe[i]) begin
                    mem[accIdx][8*i +: 8] <= accWdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.rvalid = (state_q == ST_RESP);
    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.rdata  = rdata_q;
    assign bus.fault  = fault_q;

endmodule
